// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with its own 16x-oversampling tick generator.
// Start bits are confirmed at mid-bit; data and stop are sampled one bit period apart.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  rx,
  output logic                  baudTick,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rx_ready,
  output logic                  new_byte_start,
  output logic                  new_byte_received
);

  localparam int TICK_RATE = BAUD_RATE * OVERSAMPLE;
  localparam int DIV       = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [TCNT_W-1:0] TICK_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      div_cnt;
  logic [TCNT_W-1:0]     tcnt;
  logic [BIDX_W-1:0]     bidx;
  logic                  rx_meta;
  logic                  rx_s;
  logic [DATA_WIDTH-1:0] shreg;

  // Baud tick: registered pulse on the cycle after the divider reaches DIV-1
  always_ff @(posedge clk) begin
    if (rstN) begin
      div_cnt  <= '0;
      baudTick <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      baudTick <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      baudTick <= 1'b0;
    end
  end

  // Two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rstN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Data shift register, LSB first; contents are only meaningful once framed
  always_ff @(posedge clk) begin
    if (state == DATA && baudTick && tcnt == TICK_LAST)
      shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state             <= IDLE;
      tcnt              <= '0;
      bidx              <= '0;
      dataOut           <= '0;
      rx_ready          <= 1'b1;
      new_byte_start    <= 1'b0;
      new_byte_received <= 1'b0;
    end else begin
      new_byte_start    <= 1'b0;
      new_byte_received <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            tcnt     <= '0;
            rx_ready <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baudTick) begin
            if (tcnt == TICK_MID) begin
              tcnt <= '0;
              if (!rx_s) begin
                new_byte_start <= 1'b1;
                bidx           <= '0;
                state          <= DATA;
              end else begin
                rx_ready <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (baudTick) begin
            if (tcnt == TICK_LAST) begin
              tcnt <= '0;
              bidx <= bidx + 1'b1;
              if (bidx == BIDX_LAST)
                state <= STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (baudTick) begin
            if (tcnt == TICK_LAST) begin
              tcnt <= '0;
              if (rx_s) begin
                dataOut           <= shreg;
                new_byte_received <= 1'b1;
                rx_ready          <= 1'b1;
                state             <= IDLE;
              end else begin
                state <= WAIT_IDLE;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must return high before a new frame is armed
          if (rx_s) begin
            rx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          rx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a fast-baud instance for framing behaviour and a
// default-parameter instance for the 163-clock tick rate.
`timescale 1ns/1ps
module tb_uart_rx_core;

  // Fast instance: 50 MHz / (200000*16) = 15.625 -> DIV 16, so one bit = 256 clocks
  localparam int DIV_F = 16;
  localparam int BIT   = DIV_F * 16;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       rx = 1'b1;
  logic       baudTick, rx_ready, nbs, nbr;
  logic [7:0] dataOut;
  logic       tick_def, ready_def, nbs_def, nbr_def;
  logic [7:0] data_def;

  always #10 clk = ~clk;

  uart_rx_core #(.CLK_FREQ(50_000_000), .BAUD_RATE(200_000), .DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rstN(rstN), .rx(rx), .baudTick(baudTick), .dataOut(dataOut),
    .rx_ready(rx_ready), .new_byte_start(nbs), .new_byte_received(nbr));

  uart_rx_core dut_def (
    .clk(clk), .rstN(rstN), .rx(1'b1), .baudTick(tick_def), .dataOut(data_def),
    .rx_ready(ready_def), .new_byte_start(nbs_def), .new_byte_received(nbr_def));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nbs_cnt = 0;
  int nbr_cnt = 0;
  int start_cyc = 0;
  int last_nbs = 0;
  int last_tick = 0;
  logic prev_nbs = 1'b0;
  logic prev_nbr = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: checks the fast instance against the frame-level model every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rstN) begin
        last_tick = cyc;
        chk("rst_tick", 32'(baudTick), 32'd0);
        chk("rst_data", 32'(dataOut), 32'd0);
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_pulses", 32'({nbs, nbr}), 32'd0);
      end else begin
        if (baudTick) begin
          chk("tick_period", 32'(cyc - last_tick), 32'(DIV_F));
          last_tick = cyc;
        end
        chk("pulse_excl", 32'(nbs & nbr), 32'd0);
        if (nbs) begin
          nbs_cnt++;
          chk("start_width", 32'(prev_nbs), 32'd0);
          chk("start_ready", 32'(rx_ready), 32'd0);
          chk("start_latency_ok", 32'((cyc - start_cyc) >= 112 && (cyc - start_cyc) <= 136), 32'd1);
          last_nbs = cyc;
        end
        if (nbr) begin
          nbr_cnt++;
          chk("recv_width", 32'(prev_nbr), 32'd0);
          chk("recv_after_start", 32'(cyc - last_nbs), 32'(144 * DIV_F));
          chk("recv_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) model_data = exp_q.pop_front();
          chk("recv_data", 32'(dataOut), 32'(model_data));
          chk("recv_ready", 32'(rx_ready), 32'd1);
        end else begin
          chk("data_hold", 32'(dataOut), 32'(model_data));
        end
      end
      prev_nbs = nbs;
      prev_nbr = nbr;
    end
  end

  // Caller must be at a negedge; returns at a negedge with rx idle high
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits,
                            input bit good);
    if (good) exp_q.push_back(b);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_val;
    repeat (BIT * stop_bits) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] burst [10] = '{8'h00, 8'hFF, 8'h5A, 8'h01, 8'h80, 8'hC3, 8'h7E, 8'h12, 8'hE9, 8'h36};

  initial begin
    int s0, r0;
    int tk[$];
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b0;

    // Default parameters: ticks 163 clocks apart, first one 163 clocks after release
    for (int k = 1; k <= 500; k++) begin
      @(posedge clk);
      #1;
      if (tick_def) tk.push_back(k);
    end
    chk("def_tick_count", 32'(tk.size()), 32'd3);
    if (tk.size() >= 3) begin
      chk("def_tick_first", 32'(tk[0]), 32'd163);
      chk("def_tick_second", 32'(tk[1]), 32'd326);
      chk("def_tick_third", 32'(tk[2]), 32'd489);
    end
    chk("def_idle_ready", 32'(ready_def), 32'd1);
    chk("def_idle_data", 32'(data_def), 32'd0);
    @(negedge clk);
    chk("reset_data", 32'(dataOut), 32'd0);
    chk("reset_ready", 32'(rx_ready), 32'd1);

    // Single frame 0xA5
    s0 = nbs_cnt; r0 = nbr_cnt;
    send_frame(8'hA5, 1'b1, 1, 1'b1);
    idle(BIT);
    chk("a5_starts", 32'(nbs_cnt - s0), 32'd1);
    chk("a5_recv", 32'(nbr_cnt - r0), 32'd1);
    chk("a5_data", 32'(dataOut), 32'hA5);
    chk("a5_ready", 32'(rx_ready), 32'd1);

    // Ten back-to-back frames with no idle gap
    s0 = nbs_cnt; r0 = nbr_cnt;
    for (int i = 0; i < 10; i++) send_frame(burst[i], 1'b1, 1, 1'b1);
    idle(BIT);
    chk("burst_starts", 32'(nbs_cnt - s0), 32'd10);
    chk("burst_recv", 32'(nbr_cnt - r0), 32'd10);
    chk("burst_last", 32'(dataOut), 32'h36);
    chk("burst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Quarter-bit glitch must not start a frame
    s0 = nbs_cnt; r0 = nbr_cnt;
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT / 4) @(negedge clk);
    idle(2 * BIT);
    chk("glitch_starts", 32'(nbs_cnt - s0), 32'd0);
    chk("glitch_recv", 32'(nbr_cnt - r0), 32'd0);
    chk("glitch_data", 32'(dataOut), 32'h36);
    chk("glitch_ready", 32'(rx_ready), 32'd1);

    // Framing error: 0x3C with a stop held low for two bits, then 0x81
    s0 = nbs_cnt; r0 = nbr_cnt;
    send_frame(8'h3C, 1'b0, 2, 1'b0);
    idle(BIT);
    chk("ferr_starts", 32'(nbs_cnt - s0), 32'd1);
    chk("ferr_recv", 32'(nbr_cnt - r0), 32'd0);
    chk("ferr_data", 32'(dataOut), 32'h36);
    chk("ferr_ready", 32'(rx_ready), 32'd1);
    send_frame(8'h81, 1'b1, 1, 1'b1);
    idle(BIT);
    chk("ferr_next_recv", 32'(nbr_cnt - r0), 32'd1);
    chk("ferr_next_data", 32'(dataOut), 32'h81);

    // Reset pulse in the middle of data bit 4, frame abandoned afterwards
    r0 = nbr_cnt;
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rstN = 1'b1;
    model_data = 8'h00;
    @(negedge clk);
    rstN = 1'b0;
    idle(3 * BIT);
    chk("mrst_data", 32'(dataOut), 32'd0);
    chk("mrst_ready", 32'(rx_ready), 32'd1);
    chk("mrst_recv", 32'(nbr_cnt - r0), 32'd0);
    send_frame(8'h55, 1'b1, 1, 1'b1);
    idle(BIT);
    chk("mrst_next_recv", 32'(nbr_cnt - r0), 32'd1);
    chk("mrst_next_data", 32'(dataOut), 32'h55);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART serial receiver with an integrated 16x-oversampling baud tick generator. It converts an asynchronous 8N1 serial line (`rx`) into parallel bytes and reports frame start and frame completion as single-cycle pulses. It sits at the serial-bus edge of the design, between the external `rx` pin and the byte-oriented logic that consumes received data.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 19200: line rate in bit/s.
- `DATA_WIDTH`, 8: data bits per frame.
- `OVERSAMPLE`, 16: baud ticks per bit period.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rstN`  input  1  reset. One clock; reset is synchronous and active-high (`rstN`=1 resets).
- `rx`  input  1  asynchronous serial input; idle level is 1.
- `baudTick`  output  1  one-cycle pulse at `OVERSAMPLE`×`BAUD_RATE`.
- `dataOut`  output  `DATA_WIDTH`  last correctly framed byte; held until the next good frame.
- `rx_ready`  output  1  1 when the receiver is idle and waiting for a start bit.
- `new_byte_start`  output  1  one-cycle pulse when a start bit is confirmed.
- `new_byte_received`  output  1  one-cycle pulse when `dataOut` has just been updated.

## Operation
- **Tick generator**
  - DIV = round(`CLK_FREQ`/(`BAUD_RATE`×`OVERSAMPLE`)); this is 163 for the defaults.
  - The counter is free-running over 0..DIV-1.
  - `baudTick`=1 for exactly one cycle when the counter equals DIV-1; the counter then wraps to 0.
- **Input conditioning:** `rx` passes through a 2-flop synchronizer, initialised to 1. All decisions use the synchronized value `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. A 4-bit tick counter (`tcnt`) and a bit index (`bidx`) advance only on `baudTick`.
- **IDLE**
  - `rx_ready`=1.
  - When `rx_s`=0: clear `tcnt` and go to START.
- **START**
  - On the 8th tick (mid start bit): if `rx_s`=0, pulse `new_byte_start`, clear `tcnt` and `bidx`, and go to DATA.
  - Otherwise the start is false (glitch): go to IDLE with no pulse.
- **DATA**
  - Every 16th tick: sample `rx_s` into the shift register, LSB first (shift right, new bit into the MSB).
  - When `bidx`=`DATA_WIDTH`-1 has been sampled, go to STOP.
- **STOP**
  - On the 16th tick, sample `rx_s`.
  - If 1: load `dataOut` from the shift register, pulse `new_byte_received`, and go to IDLE.
  - If 0 (framing error): `dataOut` is unchanged, no pulse, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- `rx_ready`=0 in every state except IDLE.
- **Reset mid-frame:** the frame is aborted; the FSM returns to IDLE and the partial byte is discarded.

## Timing
- **Reset values:**
  - `baudTick`=0 and tick counter=0.
  - `dataOut`=0.
  - `rx_ready`=1 from the first cycle after reset release.
  - `new_byte_start`=0 and `new_byte_received`=0.
  - FSM in IDLE, synchronizer flops=1.
- **Start detection:** START is entered 2–3 clocks after the `rx` falling edge (synchronizer latency).
- **`new_byte_start`:** asserted 8 ticks (≈0.5 bit) after START is entered.
- **Data sampling:** each data bit is sampled ≈1.0 bit after the previous sample, i.e. at mid-bit.
- **`new_byte_received`:** asserted ≈9.5 bit periods after the start edge, before the stop bit ends. A back-to-back next start bit is therefore caught.
- **Pulses:** `new_byte_start` and `new_byte_received` are each exactly one `clk` cycle wide. They are never asserted in the same cycle.
- **`dataOut`:** changes only in the same cycle as the `new_byte_received` pulse.
- **Tolerance:** a baud error of ±3% between transmitter and receiver is accepted.
- **Output timing:** all outputs are registered; there is no combinational path from `rx`.

## Test plan
1. **Tick rate:** with defaults at a 20 ns clock, `baudTick` pulses every 163 clocks. The pulse width is 1 clock, and the first pulse occurs 163 clocks after reset release.
2. **Single frame:**
   - Stimulus: send 0xA5 LSB first (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 52.083 µs/bit.
   - Required response: one `new_byte_start` pulse, then one `new_byte_received` pulse.
   - At that pulse `dataOut`=0xA5, and `rx_ready` returns to 1.
3. **Back-to-back frames:**
   - Stimulus: 10 consecutive random bytes with no idle gap, each checked against a model.
   - Required response: exactly 10 `new_byte_received` pulses with matching values.
4. **Glitch rejection:**
   - Stimulus: an `rx` low pulse of 0.25 bit.
   - Required response: no `new_byte_start`, `dataOut` unchanged, FSM back in IDLE.
5. **Framing error:**
   - Stimulus: a frame 0x3C with stop bit 0, held low for 2 bits, then 0x81 sent normally.
   - Required response: no pulse for 0x3C; `dataOut`=0x81 after the second frame.
6. **Mid-frame reset:**
   - Stimulus: assert `rstN`=1 for 1 clock during data bit 4.
   - Required response: `dataOut`=0 and `rx_ready`=1 afterwards. The next full frame 0x55 is received correctly.
